relu_pipe_fix: RTL and testbench

Multi-lane, pipelined fixed-point activation unit for the MNIST inference datapath. It sits between the neuron accumulator/MAC stage and the next layer's input buffer. Each handshake beat processes LANES signed activations. A per-beat mode selects pass-through, ReLU, leaky ReLU or clipped ReLU. Valid/ready back-pressure runs on both sides.

---
 rtl/relu_pipe_fix.sv | 125 ++++++++++++
 tb/tb_relu_pipe_fix.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_pipe_fix.sv
// relu_pipe_fix: two-stage multi-lane fixed-point activation (pass/ReLU/leaky/clip).
// Define ACT_STATS_EN to enable the saturating zero-lane counter on zero_cnt.
module relu_pipe_fix #(
  parameter int WIDTH      = 16,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       clip_val,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [31:0]            zero_cnt
);

  logic                   r_s1_valid;
  logic [LANES*WIDTH-1:0] r_s1_data;
  logic [1:0]             r_s1_mode;
  logic [WIDTH-1:0]       r_s1_clip;
  logic                   r_s2_valid;
  logic [LANES*WIDTH-1:0] r_s2_data;

  logic                   w_s1_load;
  logic                   w_s2_load;
  logic [LANES*WIDTH-1:0] w_act;

  function automatic logic [WIDTH-1:0] f_act(
    input logic signed [WIDTH-1:0] x,
    input logic        [1:0]       m,
    input logic signed [WIDTH-1:0] c
  );
    logic [WIDTH-1:0] y;
    y = x;
    unique case (m)
      2'd0: y = x;
      2'd1: y = x[WIDTH-1] ? '0 : x;
      2'd2: y = x[WIDTH-1] ? WIDTH'(x >>> LEAK_SHIFT) : x;
      2'd3: begin
        if (x[WIDTH-1] || c[WIDTH-1]) y = '0;
        else if (x > c)               y = c;
        else                          y = x;
      end
    endcase
    return y;
  endfunction

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;

  // apply the sampled mode to every lane of the S1 beat
  always_comb begin
    w_act = '0;
    for (int i = 0; i < LANES; i++) begin
      w_act[i*WIDTH +: WIDTH] =
        f_act(r_s1_data[i*WIDTH +: WIDTH], r_s1_mode, r_s1_clip);
    end
  end

  // S1: capture raw beat with its mode and clamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= '0;
      r_s1_clip  <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_mode <= mode;
        r_s1_clip <= clip_val;
      end
    end
  end

  // S2: hold activated result until downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_data <= w_act;
    end
  end

`ifdef ACT_STATS_EN
  localparam int ZW = $clog2(LANES + 1);

  logic [31:0]   r_zero_cnt;
  logic [ZW-1:0] w_nz;
  logic [32:0]   w_sum;

  // number of zero lanes in the beat currently on the output
  always_comb begin
    w_nz = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_s2_data[i*WIDTH +: WIDTH] == '0) w_nz = w_nz + ZW'(1);
    end
    w_sum = {1'b0, r_zero_cnt} + 33'(w_nz);
  end

  // saturating accumulate on each completed output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_cnt <= '0;
    end else if (r_s2_valid && out_ready) begin
      r_zero_cnt <= w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    end
  end

  assign zero_cnt = r_zero_cnt;
`else
  assign zero_cnt = '0;
`endif

endmodule

// File: tb/tb_relu_pipe_fix.sv
// tb_relu_pipe_fix: vector table, directed corner sequences and random
// traffic checked against an arithmetic reference model and scoreboard.
module tb_relu_pipe_fix;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int LS = 3;
`ifdef ACT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode;
  logic [W-1:0] clip_val;
  logic         in_valid;
  logic         in_ready;
  logic [L*W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [L*W-1:0] out_data;
  logic [31:0]  zero_cnt;

  always #5 clk = ~clk;

  relu_pipe_fix #(.WIDTH(W), .LANES(L), .LEAK_SHIFT(LS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .clip_val (clip_val),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .zero_cnt (zero_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  // reference: plain integer arithmetic per lane
  function automatic logic [63:0] model(input logic [63:0] d,
                                        input logic [1:0] m,
                                        input logic [15:0] c);
    logic [63:0] r;
    int x, y, hi;
    r  = '0;
    hi = int'($signed(c));
    if (hi < 0) hi = 0;
    for (int i = 0; i < L; i++) begin
      x = int'($signed(d[i*W +: W]));
      case (m)
        2'd0: y = x;
        2'd1: y = (x < 0) ? 0 : x;
        2'd2: y = (x < 0) ? (x - (2**LS - 1)) / (2**LS) : x;
        default: y = (x < 0) ? 0 : ((x > hi) ? hi : x);
      endcase
      r[i*W +: W] = y[W-1:0];
    end
    return r;
  endfunction

  function automatic int nzeros(input logic [63:0] d);
    int n;
    n = 0;
    for (int i = 0; i < L; i++) if (d[i*W +: W] == '0) n++;
    return n;
  endfunction

  function automatic logic [15:0] rl();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0: v = 16'h0000;
      1: v = 16'h7FFF;
      2: v = 16'h8000;
      3: v = 16'hFFFF;
      4: v = 16'h0001;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  logic [63:0] q[$];
  longint      exp_zc = 0;
  int          n_out = 0;
  logic        acc = 1'b0;
  logic        stall_p = 1'b0;
  logic [63:0] stall_d = '0;
  logic [63:0] e;

  // scoreboard and hold checks, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_zc  = 0;
      stall_p = 1'b0;
      acc     = 1'b0;
    end else begin
      if (stall_p) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, stall_d);
      end
      if (out_valid && out_ready) begin
        chk("out_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_data", out_data, e);
          exp_zc += nzeros(e);
          if (exp_zc > 64'hFFFF_FFFF) exp_zc = 64'hFFFF_FFFF;
        end
        n_out++;
      end
      stall_p = out_valid && !out_ready;
      stall_d = out_data;
      acc     = in_valid && in_ready;
      if (acc) q.push_back(model(in_data, mode, clip_val));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [15:0] c;
    logic [63:0] d;
    logic [63:0] x;
  } vec_t;

  vec_t tv[5];
  int   sent, stall_acc, n_out0;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; mode = '0; clip_val = '0; in_data = '0;

    tv[0] = '{2'd1, 16'h0000, pk(16'h0100, 16'hFF00, 16'h0000, 16'h7FFF),
                              pk(16'h0100, 16'h0000, 16'h0000, 16'h7FFF)};
    tv[1] = '{2'd2, 16'h0000, pk(16'hFF00, 16'hFFFF, 16'h8000, 16'h0040),
                              pk(16'hFFE0, 16'hFFFF, 16'hF000, 16'h0040)};
    tv[2] = '{2'd3, 16'h0600, pk(16'h0700, 16'h0600, 16'h0200, 16'hFFF0),
                              pk(16'h0600, 16'h0600, 16'h0200, 16'h0000)};
    tv[3] = '{2'd3, 16'hFFFF, pk(16'h0700, 16'h0600, 16'h0200, 16'hFFF0),
                              pk(16'h0000, 16'h0000, 16'h0000, 16'h0000)};
    tv[4] = '{2'd0, 16'h0000, pk(16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234),
                              pk(16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234)};

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_zero_cnt", zero_cnt, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 5; i++) begin
      mode = tv[i].m; clip_val = tv[i].c; in_data = tv[i].d; in_valid = 1'b1;
      chk("tv_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("tv_lat_early", out_valid, 0);
      tick();
      chk("tv_out_valid", out_valid, 1);
      chk("tv_out_data", out_data, tv[i].x);
      tick();
      chk("tv_zero_cnt", zero_cnt, STATS ? exp_zc : 0);
      if (i == 0) chk("tv1_zero_cnt", zero_cnt, STATS ? 2 : 0);
    end

    mode = 2'd1; clip_val = '0; in_data = pk(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
    in_valid = 1'b1;
    tick();
    mode = 2'd0;
    tick();
    in_valid = 1'b0;
    chk("msw_a_valid", out_valid, 1);
    chk("msw_a_data", out_data, 0);
    tick();
    chk("msw_b_valid", out_valid, 1);
    chk("msw_b_data", out_data, pk(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00));
    tick();

    n_out0 = n_out; sent = 0; stall_acc = 0;
    out_ready = 1'b0; mode = 2'd0;
    in_data = {rl(), rl(), rl(), rl()}; in_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && sent < 10; cyc++) begin
      if (cyc == 5) out_ready = 1'b1;
      tick();
      if (acc) begin
        sent++;
        if (cyc < 5) stall_acc++;
        in_data = {rl(), rl(), rl(), rl()};
      end
      if (cyc == 4) chk("bp_in_ready_low", in_ready, 0);
      if (sent == 10) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_stall_accepts", stall_acc, 2);
    chk("bp_sent", sent, 10);
    repeat (5) tick();
    chk("bp_received", n_out - n_out0, 10);
    chk("bp_sb_empty", q.size(), 0);

    mode = 2'd1;
    in_data = pk(16'h0000, 16'h8000, 16'h0005, 16'h0000); in_valid = 1'b1;
    tick();
    in_data = pk(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_zero_cnt", zero_cnt, 0);
    chk("rst_mid_data", out_data, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_rel_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      chk("rst_no_stale", out_valid, 0);
      tick();
    end

    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        mode     = 2'($urandom);
        clip_val = rl();
        in_data  = {rl(), rl(), rl(), rl()};
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (q.size() != 0 || out_valid); c++) tick();
    chk("rnd_sb_empty", q.size(), 0);
    chk("rnd_drained", out_valid, 0);
    tick();
    chk("final_zero_cnt", zero_cnt, STATS ? exp_zc : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
